glu_i2s_out: RTL and testbench

Downstream audio output stage for the IIgs sound path. It consumes the signed 16-bit left and right mixes produced by the GLU/DOC block on `clk_logic`. It applies the GLU 4-bit volume with a click-free per-frame gain ramp and mute, then serializes the result as Philips-format I2S (BCLK, LRCK, SDATA) for the board audio codec. The block generates its own bit and frame timing by dividing `clk_logic`; no other clock is involved.

---
 rtl/glu_i2s_out.sv | 139 +++++++++++++
 tb/tb_glu_i2s_out.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glu_i2s_out.sv
// Audio output stage: per-frame ramped GLU volume/mute gain applied to the
// signed L/R mixes, serialized as Philips I2S with locally divided BCLK/LRCK.
module glu_i2s_out #(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic        clk_logic,
  input  logic        system_reset,
  input  logic [15:0] audio_l_i,
  input  logic [15:0] audio_r_i,
  input  logic [3:0]  volume_i,
  input  logic        mute_i,
  output logic        i2s_bclk_o,
  output logic        i2s_lrck_o,
  output logic        i2s_sdata_o,
  output logic        frame_strobe_o,
  output logic [4:0]  gain_o
);

  localparam int unsigned AUDIO_W = 16;
  localparam int unsigned GAIN_W  = 5;
  localparam int unsigned MUL_W   = 22;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned SLOT_W  = 5;
  localparam int unsigned DIV_W   = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               bclk_q, bclk_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               strobe_q, strobe_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic [AUDIO_W-1:0] word_l_q, word_l_d;
  logic [AUDIO_W-1:0] word_r_q, word_r_d;
  logic [AUDIO_W-1:0] prod_l_q, prod_l_d;
  logic [AUDIO_W-1:0] prod_r_q, prod_r_d;

  logic signed [MUL_W-1:0] mul_l, mul_r;
  logic                    tick, fall, wrap;
  logic [SLOT_W-1:0]       slot;
  logic [AUDIO_W-1:0]      word_sel;
  logic [GAIN_W-1:0]       target;

  // Gain scaling; the arithmetic shift floors, and -32768*16>>>4 still fits 16 bits
  always_comb begin
    mul_l    = MUL_W'($signed(audio_l_i)) * MUL_W'($signed({1'b0, gain_q}));
    mul_r    = MUL_W'($signed(audio_r_i)) * MUL_W'($signed({1'b0, gain_q}));
    prod_l_d = AUDIO_W'(mul_l >>> 4);
    prod_r_d = AUDIO_W'(mul_r >>> 4);
  end

  // Bit/frame timing, serializer and per-frame gain ramp
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    strobe_d  = 1'b0;
    gain_d    = gain_q;
    word_l_d  = word_l_q;
    word_r_d  = word_r_q;
    slot      = '0;
    word_sel  = '0;

    target = mute_i ? '0 : GAIN_W'(volume_i) + GAIN_W'(1);
    tick   = (div_cnt_q == DIV_TC);
    fall   = tick && bclk_q;
    wrap   = fall && (bit_cnt_q == BIT_W'(63));

    if (tick) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (fall) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      lrck_d    = bit_cnt_d[5];
      slot      = bit_cnt_d[4:0];
      word_sel  = bit_cnt_d[5] ? word_r_q : word_l_q;
      // slot 0 is the I2S one-bit delay; 17..31 are zero padding
      if ((slot != '0) && (slot <= SLOT_W'(16))) begin
        sdata_d = word_sel[4'(SLOT_W'(16) - slot)];
      end else begin
        sdata_d = 1'b0;
      end
    end

    // Words latch with the pre-update gain, then gain steps one toward target
    if (wrap) begin
      word_l_d = prod_l_q;
      word_r_d = prod_r_q;
      strobe_d = 1'b1;
      if (gain_q < target) begin
        gain_d = gain_q + GAIN_W'(1);
      end else if (gain_q > target) begin
        gain_d = gain_q - GAIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
      gain_q    <= '0;
      word_l_q  <= '0;
      word_r_q  <= '0;
      prod_l_q  <= '0;
      prod_r_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      strobe_q  <= strobe_d;
      gain_q    <= gain_d;
      word_l_q  <= word_l_d;
      word_r_q  <= word_r_d;
      prod_l_q  <= prod_l_d;
      prod_r_q  <= prod_r_d;
    end
  end

  assign i2s_bclk_o     = bclk_q;
  assign i2s_lrck_o     = lrck_q;
  assign i2s_sdata_o    = sdata_q;
  assign frame_strobe_o = strobe_q;
  assign gain_o         = gain_q;

endmodule

// File: tb/tb_glu_i2s_out.sv
// Scoreboarded bench for glu_i2s_out: a frame-level model predicts each
// transmitted L/R word pair and gain; a deserializing monitor checks them.
module tb_glu_i2s_out;

  localparam int unsigned BCLK_DIV = 2;
  localparam int FRAME = 128 * BCLK_DIV;

  logic        clk_logic = 1'b0;
  logic        system_reset = 1'b1;
  logic [15:0] audio_l_i = '0;
  logic [15:0] audio_r_i = '0;
  logic [3:0]  volume_i = '0;
  logic        mute_i = 1'b0;
  logic        i2s_bclk_o, i2s_lrck_o, i2s_sdata_o, frame_strobe_o;
  logic [4:0]  gain_o;

  always #5 clk_logic = ~clk_logic;

  glu_i2s_out #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk_logic      (clk_logic),
    .system_reset   (system_reset),
    .audio_l_i      (audio_l_i),
    .audio_r_i      (audio_r_i),
    .volume_i       (volume_i),
    .mute_i         (mute_i),
    .i2s_bclk_o     (i2s_bclk_o),
    .i2s_lrck_o     (i2s_lrck_o),
    .i2s_sdata_o    (i2s_sdata_o),
    .frame_strobe_o (frame_strobe_o),
    .gain_o         (gain_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: floor(a * g / 16) on the signed sample
  function automatic logic [15:0] scale(input logic [15:0] a, input int g);
    int p;
    p = int'($signed(a)) * g;
    if (p >= 0) return 16'(p / 16);
    return 16'(-((-p + 15) / 16));
  endfunction

  // Expected slot stream for one frame, indexed by slot number
  function automatic logic [63:0] serial_frame(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] b;
    b = '0;
    for (int s = 1; s <= 16; s++) begin
      b[s]      = l[16 - s];
      b[32 + s] = r[16 - s];
    end
    return b;
  endfunction

  // Cycle count since reset release, as seen by the DUT at each rising edge
  logic rst_q = 1'b1;
  int   cyc = 0;
  always @(posedge clk_logic) begin
    rst_q <= system_reset;
    cyc   <= system_reset ? 0 : cyc + 1;
  end

  logic [31:0] exp_q[$];
  int          g_model = 0;
  int          target;
  int          last_strobe = 0;
  bit          mon_active = 0;
  int          slot = 0;
  int          lrck_err = 0;
  logic [63:0] bits = '0;
  logic [31:0] e;
  bit          seen_rise = 0, seen_fall = 0;
  logic        prev_bclk = 1'b0, prev_lrck = 1'b0, prev_sdata = 1'b0;

  // Model + monitor, sampled on the falling clock edge
  always @(negedge clk_logic) begin
    if (rst_q) begin
      check("reset_outputs", {i2s_bclk_o, i2s_lrck_o, i2s_sdata_o, frame_strobe_o, gain_o}, 64'd0);
      g_model = 0;
      exp_q.delete();
      mon_active = 0;
      seen_rise = 0;
      seen_fall = 0;
      last_strobe = 0;
    end else begin
      if (!prev_bclk && i2s_bclk_o && !seen_rise) begin
        check("first_bclk_rise", cyc, BCLK_DIV);
        seen_rise = 1;
      end
      if (prev_bclk && !i2s_bclk_o && !seen_fall) begin
        check("first_bclk_fall", cyc, 2 * BCLK_DIV);
        seen_fall = 1;
      end
      if (i2s_lrck_o !== prev_lrck || i2s_sdata_o !== prev_sdata)
        check("data_edge_bclk", {prev_bclk, i2s_bclk_o}, 2'b10);

      if (mon_active && !prev_bclk && i2s_bclk_o) begin
        bits[slot] = i2s_sdata_o;
        if (i2s_lrck_o !== (slot >= 32)) lrck_err++;
        slot++;
        if (slot == 64) begin
          mon_active = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_scoreboard: got a frame, expected none queued at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("frame_bits", bits, serial_frame(e[31:16], e[15:0]));
            check("frame_lrck_errs", lrck_err, 0);
          end
        end
      end

      if (frame_strobe_o) begin
        check("strobe_interval", cyc - last_strobe, FRAME);
        last_strobe = cyc;
        if (mon_active) begin
          checks++;
          errors++;
          $display("FAIL frame_length: got %0d slots, expected 64 at %0t", slot, $time);
        end
        exp_q.push_back({scale(audio_l_i, g_model), scale(audio_r_i, g_model)});
        target = mute_i ? 0 : int'(volume_i) + 1;
        if (g_model < target) g_model++;
        else if (g_model > target) g_model--;
        mon_active = 1;
        slot = 0;
        lrck_err = 0;
      end
      check("gain", gain_o, g_model);
    end
    prev_bclk  = i2s_bclk_o;
    prev_lrck  = i2s_lrck_o;
    prev_sdata = i2s_sdata_o;
  end

  // Waits for n strobes, leaving the driver mid-frame so input changes never hit a wrap
  task automatic wait_frames(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!frame_strobe_o && t < 2 * FRAME) begin
        @(posedge clk_logic); #1;
        t++;
      end
      if (!frame_strobe_o) begin
        checks++;
        errors++;
        $display("FAIL strobe_timeout: got no strobe within %0d cycles", 2 * FRAME);
      end
      repeat (FRAME / 4) begin
        @(posedge clk_logic); #1;
      end
    end
  endtask

  initial begin
    int t;
    repeat (5) @(posedge clk_logic);
    #1 system_reset = 1'b0;

    // Ramp-up from reset at unity target
    volume_i  = 4'd15;
    audio_l_i = 16'h4000;
    audio_r_i = 16'($urandom);
    wait_frames(20);
    check("ramp_up_gain", gain_o, 16);

    // Steady scaling at gain 8, including flooring of -1
    volume_i  = 4'd7;
    audio_l_i = 16'h7FFE;
    audio_r_i = 16'h8000;
    wait_frames(10);
    check("vol7_gain", gain_o, 8);
    audio_l_i = 16'hFFFF;
    audio_r_i = 16'($urandom);
    wait_frames(3);

    // Serial format at unity
    volume_i  = 4'd15;
    audio_l_i = 16'hA5A5;
    audio_r_i = 16'h5A5A;
    wait_frames(11);

    // Mute together with a volume change, mid-frame
    mute_i   = 1'b1;
    volume_i = 4'd3;
    repeat (8) @(posedge clk_logic);
    #1 check("mute_no_midframe_change", gain_o, 16);
    wait_frames(17);
    check("mute_gain_zero", gain_o, 0);
    mute_i = 1'b0;
    wait_frames(6);
    check("unmute_gain_four", gain_o, 4);

    // Randomized audio, volume and mute
    for (int i = 0; i < 20; i++) begin
      audio_l_i = 16'($urandom);
      audio_r_i = 16'($urandom);
      if ($urandom_range(0, 2) == 0) volume_i = 4'($urandom_range(0, 15));
      mute_i = ($urandom_range(0, 4) == 0);
      wait_frames(1);
    end

    // One-cycle reset at slot 40
    mute_i = 1'b0;
    t = 0;
    while (!(mon_active && slot == 40) && t < 2 * FRAME) begin
      @(posedge clk_logic); #1;
      t++;
    end
    if (!(mon_active && slot == 40)) begin
      checks++;
      errors++;
      $display("FAIL slot40_timeout: got slot %0d, expected 40", slot);
    end
    system_reset = 1'b1;
    @(posedge clk_logic); #1;
    system_reset = 1'b0;
    audio_l_i = 16'h1234;
    audio_r_i = 16'hEDCB;
    wait_frames(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(10 * 100000);
    $display("FAIL global_timeout: got no finish, expected finish within 100000 cycles");
    $fatal(1, "timeout");
  end

endmodule
